// File: rtl/alu_exec_pkg.sv
// Shared op-codes, FSM states and flag bit positions for the ALU execute sequencer.
package alu_exec_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  // Flags = {OF, CF, ZF}
  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 2;
endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU for every op except MUL; carry/overflow only meaningful for ADD/SUB.
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cf,
  output logic             o_of
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_cf     = 1'b0;
    o_of     = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_cf     = w_sum[WIDTH];
        o_of     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_cf     = w_diff[WIDTH];
        o_of     = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SLT: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Fetch/execute/write-back sequencer around the register file: IDLE -> READ -> EXEC -> WB,
// with a bit-serial shift-add multiply that stays in EXEC for WIDTH cycles.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [AW-1:0]    A_Addr,
  input  logic [AW-1:0]    B_Addr,
  input  logic [AW-1:0]    D_Addr,
  output logic [AW-1:0]    R_Addr_A,
  output logic [AW-1:0]    R_Addr_B,
  input  logic [WIDTH-1:0] R_Data_A,
  input  logic [WIDTH-1:0] R_Data_B,
  output logic [AW-1:0]    W_Addr,
  output logic [WIDTH-1:0] W_Data,
  output logic             Write_Reg,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       Flags
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [AW-1:0]     r_d;
  logic [AW-1:0]     r_raddr_a;
  logic [AW-1:0]     r_raddr_b;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_flags_pend;
  logic [2:0]        r_flags;
  logic [AW-1:0]     r_waddr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_wr;
  logic              r_done;
  logic              r_busy;

  logic [WIDTH-1:0]  w_alu_res;
  logic              w_cf;
  logic              w_of;
  logic [WIDTH-1:0]  w_acc_step;
  logic [WIDTH-1:0]  w_result;
  logic              w_mul_last;
  logic [2:0]        w_flags_nxt;

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_cf     (w_cf),
    .o_of     (w_of)
  );

  // During MUL, r_a is the shifting multiplicand and r_b the shifting multiplier.
  assign w_acc_step = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
  assign w_result   = (r_op == OP_MUL) ? w_acc_step : w_alu_res;

  always_comb begin
    w_flags_nxt          = '0;
    w_flags_nxt[FLAG_ZF] = (w_result == '0);
    w_flags_nxt[FLAG_CF] = w_cf;
    w_flags_nxt[FLAG_OF] = w_of;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  if ((r_op != OP_MUL) || w_mul_last) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_op         <= '0;
      r_d          <= '0;
      r_raddr_a    <= '0;
      r_raddr_b    <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flags_pend <= '0;
      r_flags      <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (Start) begin
          r_op      <= Op;
          r_d       <= D_Addr;
          r_raddr_a <= A_Addr;
          r_raddr_b <= B_Addr;
          r_busy    <= 1'b1;
        end
        S_READ: begin
          r_a   <= R_Data_A;
          r_b   <= R_Data_B;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_step;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
          // Output registers load on the EXEC->WB edge so they are live during WB.
          if (w_next == S_WB) begin
            r_waddr      <= r_d;
            r_wdata      <= w_result;
            r_wr         <= (r_d != '0);
            r_done       <= 1'b1;
            r_flags_pend <= w_flags_nxt;
          end
        end
        S_WB: begin
          r_flags <= r_flags_pend;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign R_Addr_A  = r_raddr_a;
  assign R_Addr_B  = r_raddr_b;
  assign W_Addr    = r_waddr;
  assign W_Data    = r_wdata;
  assign Write_Reg = r_wr;
  assign Done      = r_done;
  assign Busy      = r_busy;
  assign Flags     = r_flags;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them on every Done.
module tb_alu_exec_unit;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [AW-1:0]    d;
    logic [WIDTH-1:0] data;
    logic [2:0]       flags;
    logic             wr;
    int               lat;
    int               issue;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [2:0]       Op = '0;
  logic [AW-1:0]    A_Addr = '0, B_Addr = '0, D_Addr = '0;
  logic [AW-1:0]    R_Addr_A, R_Addr_B, W_Addr;
  logic [WIDTH-1:0] R_Data_A, R_Data_B, W_Data;
  logic             Write_Reg, Busy, Done;
  logic [2:0]       Flags;

  logic [WIDTH-1:0] regs [32];
  logic             tb_we = 1'b0;
  logic [AW-1:0]    tb_wa = '0;
  logic [WIDTH-1:0] tb_wd = '0;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  exp_t             exp_q[$];

  alu_exec_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .A_Addr(A_Addr), .B_Addr(B_Addr), .D_Addr(D_Addr),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Busy(Busy), .Done(Done), .Flags(Flags)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Register file: combinational read, write on the clock edge; register 0 is read-only.
  assign R_Data_A = regs[R_Addr_A];
  assign R_Data_B = regs[R_Addr_B];
  always @(posedge Clk) begin
    if (tb_we && tb_wa != '0) regs[tb_wa] <= tb_wd;
    else if (Write_Reg && W_Addr != '0) regs[W_Addr] <= W_Data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    logic [32:0] s;
    logic [63:0] p;
    longint sa, sb, sr;
    logic cf, of;
    logic [WIDTH-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cf = 1'b0; of = 1'b0; r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cf = s[32];
        sr = sa + sb; of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd5: begin
        r = a - b; cf = (a < b);
        sr = sa - sb; of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      default: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
    endcase
    e.d = d; e.data = r; e.flags = {of, cf, (r == 0)}; e.wr = (d != 0);
    e.lat = (op == 3'd7) ? 34 : 3;
    e.issue = 0;
    return e;
  endfunction

  task automatic setreg(input int a, input logic [WIDTH-1:0] v);
    @(negedge Clk);
    tb_we = 1'b1; tb_wa = AW'(a); tb_wd = v;
    @(negedge Clk);
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input int a, input int b, input int d);
    exp_t e;
    @(negedge Clk);
    e = model(op, regs[a], regs[b], AW'(d));
    e.issue = cyc + 1;
    exp_q.push_back(e);
    Op = op; A_Addr = AW'(a); B_Addr = AW'(b); D_Addr = AW'(d); Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_start", {63'b0, Busy}, 64'd1);
  endtask

  task automatic wait_idle(input int exp_n);
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("busy_cycles", 64'(n), 64'(exp_n));
  endtask

  // Monitor: every Done pops one expectation; flags are checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset && Write_Reg && !Done) chk("write_without_done", {63'b0, Write_Reg}, 64'd0);
      if (Reset && Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {63'b0, Done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("w_addr", 64'(W_Addr), 64'(e.d));
          chk("w_data", 64'(W_Data), 64'(e.data));
          chk("write_reg", {63'b0, Write_Reg}, {63'b0, e.wr});
          chk("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
          @(negedge Clk);
          chk("flags", 64'(Flags), 64'(e.flags));
          chk("done_pulse_width", {63'b0, Done}, 64'd0);
          chk("write_pulse_width", {63'b0, Write_Reg}, 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] edge_v [5];
    logic [WIDTH-1:0] keep;
    logic [2:0] op;
    edge_v[0] = 32'h0; edge_v[1] = 32'h7FFF_FFFF; edge_v[2] = 32'h8000_0000;
    edge_v[3] = 32'hFFFF_FFFF; edge_v[4] = 32'h1;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h0101_0101);
    regs[0] = '0;

    #3 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    chk("rst_write", {63'b0, Write_Reg}, 64'd0);
    chk("rst_wdata", 64'(W_Data), 64'd0);
    chk("rst_flags", 64'(Flags), 64'd0);
    Reset = 1'b1;

    // ADD 5+3 into r3
    setreg(1, 32'd5); setreg(2, 32'd3);
    issue(3'd4, 1, 2, 3); wait_idle(3);
    chk("r3_written", 64'(regs[3]), 64'd8);

    // signed overflow on ADD, then borrow on SUB
    setreg(1, 32'h7FFF_FFFF); setreg(2, 32'd1);
    issue(3'd4, 1, 2, 4); wait_idle(3);
    setreg(1, 32'd0);
    issue(3'd5, 1, 2, 5); wait_idle(3);

    // MUL with an ignored second Start at edge k+5
    setreg(1, 32'h0001_0001); setreg(2, 32'h0001_0000);
    issue(3'd7, 1, 2, 6);
    repeat (4) @(negedge Clk);
    Op = 3'd4; A_Addr = 5'd1; B_Addr = 5'd1; D_Addr = 5'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle(29);
    repeat (6) @(negedge Clk);
    chk("ignored_start_busy", {63'b0, Busy}, 64'd0);

    // XOR with itself into r0: Done without write, ZF set
    issue(3'd2, 1, 1, 0); wait_idle(3);
    chk("r0_untouched", 64'(regs[0]), 64'd0);

    // signed SLT both ways
    setreg(1, 32'hFFFF_FFFF); setreg(2, 32'd1);
    issue(3'd6, 1, 2, 7); wait_idle(3);
    issue(3'd6, 2, 1, 8); wait_idle(3);

    // A = B = D hazard case
    issue(3'd4, 7, 7, 7); wait_idle(3);

    // Reset during MUL EXEC: outputs clear at once, no write ever lands
    setreg(10, 32'h1234_5678); keep = regs[11];
    issue(3'd7, 10, 10, 11);
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, Busy}, 64'd0);
    chk("midrst_done", {63'b0, Done}, 64'd0);
    chk("midrst_write", {63'b0, Write_Reg}, 64'd0);
    chk("midrst_waddr", 64'(W_Addr), 64'd0);
    chk("midrst_wdata", 64'(W_Data), 64'd0);
    chk("midrst_raddr", 64'({R_Addr_A, R_Addr_B}), 64'd0);
    chk("midrst_flags", 64'(Flags), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (40) @(negedge Clk);
    chk("midrst_idle", {63'b0, Busy}, 64'd0);
    chk("midrst_no_write", 64'(regs[11]), 64'(keep));

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        setreg($urandom_range(1, 31),
               ($urandom_range(0, 1) == 1) ? edge_v[$urandom_range(0, 4)] : 32'($urandom));
      op = 3'($urandom_range(0, 7));
      issue(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      wait_idle((op == 3'd7) ? 34 : 3);
    end

    repeat (4) @(negedge Clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Operand-fetch / execute / write-back sequencer that sits around the `shiyan4` register file. It drives the file's read addresses and consumes `R_Data_A`/`R_Data_B`. It computes one of eight ALU operations, including a 32-cycle shift-add multiply. It produces the `W_Addr` / `W_Data` / `Write_Reg` write-back that the register file consumes. Condition flags are held for the LED display path.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `AW`, 5, register address width

Ports:
- `Clk`  in  1  single clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  request pulse; sampled only in IDLE
- `Op`  in  3  operation: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (signed), 111 MUL (low WIDTH bits)
- `A_Addr`, `B_Addr`, `D_Addr`  in  AW  source A, source B, destination register
- `R_Addr_A`, `R_Addr_B`  out  AW  read addresses to the register file
- `R_Data_A`, `R_Data_B`  in  WIDTH  register-file read data; combinational w.r.t. the read address
- `W_Addr`  out  AW  write-back address
- `W_Data`  out  WIDTH  write-back data
- `Write_Reg`  out  1  write enable, one-cycle pulse
- `Busy`  out  1  high from the cycle after Start acceptance through the WB cycle
- `Done`  out  1  one-cycle pulse in the WB cycle
- `Flags`  out  3  {OF, CF, ZF} of the last completed operation

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - `Start=1` latches `Op`, `A_Addr`, `B_Addr`, `D_Addr` and moves to READ.
  - `Start` in any other state is ignored and not queued.
- READ:
  - `R_Addr_A`/`R_Addr_B` are driven from the latched addresses.
  - Operands A and B are captured at the end of the cycle.
  - Next state is EXEC.
- EXEC, non-MUL: one cycle; the result and flags are computed combinationally and registered; next state is WB.
- EXEC, MUL: 32 iterations, one per cycle.
  - Each iteration: if multiplier bit 0 = 1, then acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - acc is WIDTH bits and wraps modulo 2^WIDTH.
  - WB follows the 32nd iteration.
- WB:
  - `W_Addr` = latched `D_Addr`, `W_Data` = result, `Done`=1.
  - `Write_Reg`=1 unless `D_Addr`=0; register 0 is never written, but `Done` still pulses.
  - `Flags` update at the end of WB; next state is IDLE.
- Flags:
  - ZF = (result == 0) for all ops.
  - ADD: CF = carry out; OF = signed overflow.
  - SUB: CF = borrow (A < B unsigned); OF = signed overflow.
  - Logical ops, SLT, MUL: CF = OF = 0.
- SLT result is 32'd1 or 32'd0.
- A = B register addresses, including both equal to `D_Addr`, are legal. Operands are captured before write-back, so there is no hazard.

## Timing
- Reset asserted, at any time including mid-operation:
  - state goes to IDLE, no write is issued.
  - `Write_Reg`, `Done`, `Busy`, `W_Addr`, `W_Data`, `R_Addr_A`, `R_Addr_B`, `Flags` all go to 0.
  - The multiply accumulator clears.
- Start accepted at edge k: READ in cycle k..k+1, EXEC k+1..k+2, WB k+2..k+3.
- `Write_Reg`/`Done` are high for exactly one cycle, so the register file writes at edge k+3 (non-MUL latency 3 edges). MUL latency is 34 edges.
- `Busy` is 1 from edge k through edge k+3. A `Start` seen on the same edge that returns the block to IDLE is not accepted; the earliest new acceptance is edge k+4.
- All outputs are registered. `W_Addr` / `W_Data` hold their values after WB until the next WB.

## Structure
- Package `alu_exec_pkg`:
  - op-code localparams `OP_AND` … `OP_MUL`
  - state encoding `S_IDLE`, `S_READ`, `S_EXEC`, `S_WB`
  - flag bit indices
- Sub-module `alu_comb`: purely combinational; (Op, A, B) → (result, CF, OF) for non-MUL ops.
- The top level holds the FSM, the operand/address latches, the multiply datapath and the output registers.

## Test plan
- Reset mid-MUL (cycle 10 of EXEC) → all outputs 0 immediately, no `Write_Reg` pulse, IDLE after release.
- R1=5, R2=3, ADD D=3 → `Write_Reg` one cycle, 3 edges after Start; W_Addr=3, W_Data=8, Flags=000.
- R1=32'h7FFFFFFF, R2=1, ADD → W_Data=32'h80000000, OF=1, CF=0. Then SUB with R1=0, R2=1 → W_Data=32'hFFFFFFFF, CF=1, ZF=0.
- MUL R1=32'h00010001, R2=32'h00010000 → Done at 34 edges, W_Data=32'h00010000. A second Start issued at edge 5 is ignored.
- XOR R1 with itself, D=0 → Done pulses, `Write_Reg` stays 0, ZF=1.
- SLT R1=32'hFFFFFFFF (-1), R2=1 → W_Data=1. Swapping the operands → W_Data=0.
